// File: rtl/board_frame_swap_ctrl.sv
// Double-buffered board store: the loader fills the back bank while the scanner
// reads the front bank; banks flip only on a scanner end-of-frame.
module board_frame_swap_ctrl #(
  parameter int ROWS = 32,
  parameter int COLS = 32,
  parameter int CW   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          wr_valid,
  input  logic [CW-1:0] wr_data,
  input  logic          frame_end,
  input  logic          scan_frame_done,
  input  logic [4:0]    rd_row,
  input  logic [4:0]    rd_col,
  output logic [CW-1:0] rd_color,
  output logic          wr_ready,
  output logic          swap_pending,
  output logic          front_sel,
  output logic          shown_valid,
  output logic          drop_err,
  output logic          short_err,
  output logic [7:0]    frames_shown
);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          front_sel_q, front_sel_d;
  logic          shown_valid_q, shown_valid_d;
  logic [7:0]    frames_q, frames_d;
  logic [CW-1:0] rd_color_q, rd_color_d;
  logic          drop_err_q, drop_err_d;
  logic          short_err_q, short_err_d;
  logic          wr_ready_q, wr_ready_d;
  logic          swap_pending_q, swap_pending_d;

  logic          we;
  logic          full;
  logic [AW-1:0] ptr_nxt;
  int            rd_r, rd_c;
  logic [AW-1:0] rd_addr;
  logic          rd_ok;

  logic [CW-1:0] bank0 [CELLS];
  logic [CW-1:0] bank1 [CELLS];

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    front_sel_d   = front_sel_q;
    shown_valid_d = shown_valid_q;
    frames_d      = frames_q;
    drop_err_d    = 1'b0;
    short_err_d   = 1'b0;
    we            = 1'b0;
    full          = 1'b0;
    ptr_nxt       = wr_ptr_q;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
        end
      end
      LOAD: begin
        if (frame_start) begin
          // Abort restarts the load; a same-cycle write is dropped.
          wr_ptr_d = '0;
        end else begin
          if (wr_valid) begin
            we = 1'b1;
            if (wr_ptr_q == AW'(CELLS - 1)) full = 1'b1;
            else                            ptr_nxt = wr_ptr_q + 1'b1;
          end
          wr_ptr_d = ptr_nxt;
          if (full) begin
            state_d = WAIT_SWAP;
          end else if (frame_end) begin
            if (ptr_nxt == '0) begin
              state_d = IDLE;
            end else begin
              state_d     = WAIT_SWAP;
              short_err_d = 1'b1;
            end
          end
        end
      end
      WAIT_SWAP: begin
        if (frame_start) drop_err_d = 1'b1;
        if (scan_frame_done) begin
          front_sel_d   = ~front_sel_q;
          shown_valid_d = 1'b1;
          frames_d      = frames_q + 8'd1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ready_d     = (state_d == LOAD);
    swap_pending_d = (state_d == WAIT_SWAP);

    // Front bank lookup; blanked until a frame has actually been swapped in.
    rd_r       = int'(rd_row);
    rd_c       = int'(rd_col);
    rd_ok      = shown_valid_q && (rd_r < ROWS) && (rd_c < COLS);
    rd_addr    = AW'(rd_r * COLS + rd_c);
    rd_color_d = '0;
    if (rd_ok) rd_color_d = front_sel_q ? bank1[rd_addr] : bank0[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      front_sel_q    <= 1'b0;
      shown_valid_q  <= 1'b0;
      frames_q       <= 8'd0;
      rd_color_q     <= '0;
      drop_err_q     <= 1'b0;
      short_err_q    <= 1'b0;
      wr_ready_q     <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      front_sel_q    <= front_sel_d;
      shown_valid_q  <= shown_valid_d;
      frames_q       <= frames_d;
      rd_color_q     <= rd_color_d;
      drop_err_q     <= drop_err_d;
      short_err_q    <= short_err_d;
      wr_ready_q     <= wr_ready_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  // Storage is not reset; writes only ever land in the back bank.
  always_ff @(posedge clk) begin
    if (we) begin
      if (front_sel_q) bank0[wr_ptr_q] <= wr_data;
      else             bank1[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_color     = rd_color_q;
  assign wr_ready     = wr_ready_q;
  assign swap_pending = swap_pending_q;
  assign front_sel    = front_sel_q;
  assign shown_valid  = shown_valid_q;
  assign drop_err     = drop_err_q;
  assign short_err    = short_err_q;
  assign frames_shown = frames_q;
endmodule

// File: tb/tb_board_frame_swap_ctrl.sv
// Randomized bench for board_frame_swap_ctrl against a bank-array reference model.
module tb_board_frame_swap_ctrl;
  localparam int ROWS = 32, COLS = 32, CW = 2, N = ROWS * COLS;

  logic          clk = 1'b0, reset = 1'b1;
  logic          frame_start = 1'b0, wr_valid = 1'b0, frame_end = 1'b0, scan_frame_done = 1'b0;
  logic [CW-1:0] wr_data = '0;
  logic [4:0]    rd_row = '0, rd_col = '0;
  logic [CW-1:0] rd_color;
  logic          wr_ready, swap_pending, front_sel, shown_valid, drop_err, short_err;
  logic [7:0]    frames_shown;

  board_frame_swap_ctrl #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .wr_valid(wr_valid),
    .wr_data(wr_data), .frame_end(frame_end), .scan_frame_done(scan_frame_done),
    .rd_row(rd_row), .rd_col(rd_col), .rd_color(rd_color), .wr_ready(wr_ready),
    .swap_pending(swap_pending), .front_sel(front_sel), .shown_valid(shown_valid),
    .drop_err(drop_err), .short_err(short_err), .frames_shown(frames_shown)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // Reference: contents of both banks, which bank is shown, swap count, cells loaded.
  logic [CW-1:0] mb [2][N];
  int m_front = 0, m_frames = 0, m_shown = 0, m_ptr = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_cells(input int n, input bit pattern);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      wr_valid = 1'b1;
      wr_data  = pattern ? CW'(m_ptr % 4) : CW'($urandom_range(0, 3));
      mb[1 - m_front][m_ptr] = wr_data;
      m_ptr++;
      tick();
      wr_valid = 1'b0;
    end
  endtask

  task automatic do_swap();
    scan_frame_done = 1'b1;
    tick();
    scan_frame_done = 1'b0;
    m_front  = 1 - m_front;
    m_frames = (m_frames + 1) % 256;
    m_shown  = 1;
    m_ptr    = 0;
  endtask

  task automatic rd(input int r, input int c, output logic [CW-1:0] v);
    rd_row = 5'(r);
    rd_col = 5'(c);
    tick();
    v = rd_color;
  endtask

  function automatic logic [CW-1:0] exp_color(input int r, input int c);
    return m_shown != 0 ? mb[m_front][r * COLS + c] : '0;
  endfunction

  task automatic check_random_reads(input string tag, input int n);
    logic [CW-1:0] v;
    int r, c;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, ROWS - 1);
      c = $urandom_range(0, COLS - 1);
      rd(r, c, v);
      checks++;
      if (v !== exp_color(r, c)) begin
        errors++;
        $display("FAIL %s read(%0d,%0d): got %0d expected %0d", tag, r, c, v, exp_color(r, c));
      end
    end
  endtask

  task automatic test_reset();
    logic [CW-1:0] v;
    tick(); tick();
    checks++;
    if ({rd_color, wr_ready, swap_pending, front_sel, shown_valid, drop_err, short_err, frames_shown} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {rd_color, wr_ready, swap_pending, front_sel, shown_valid, drop_err, short_err, frames_shown});
    end
    reset = 1'b0;
    tick();
    rd(7, 9, v);
    checks++;
    if (v !== '0) begin errors++; $display("FAIL reset_rd_color: got %0d expected 0", v); end
  endtask

  task automatic test_short_frame();
    logic [CW-1:0] v;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    write_cells(10, 1'b0);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    checks++;
    if (short_err !== 1'b1 || swap_pending !== 1'b1) begin
      errors++; $display("FAIL short_pulse: short_err=%0b swap_pending=%0b expected 1 1", short_err, swap_pending);
    end
    tick();
    checks++;
    if (short_err !== 1'b0) begin errors++; $display("FAIL short_once: got %0b expected 0", short_err); end
    rd(0, 9, v);
    checks++;
    if (v !== '0) begin errors++; $display("FAIL short_blank_before_swap: got %0d expected 0", v); end
    do_swap();
    checks++;
    if (front_sel !== 1'b1 || frames_shown !== 8'd1 || shown_valid !== 1'b1) begin
      errors++; $display("FAIL short_swap: front=%0b frames=%0d shown=%0b expected 1 1 1", front_sel, frames_shown, shown_valid);
    end
    rd(0, 9, v);
    checks++;
    if (v !== mb[1][9]) begin errors++; $display("FAIL short_cell9: got %0d expected %0d", v, mb[1][9]); end
    rd(0, 10, v);
    checks++;
    if (v !== '0) begin errors++; $display("FAIL short_cell10: got %0d expected 0", v); end
  endtask

  task automatic test_full_frame();
    logic [CW-1:0] v;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    write_cells(N - 1, 1'b1);
    checks++;
    if (wr_ready !== 1'b1 || swap_pending !== 1'b0) begin
      errors++; $display("FAIL full_before_last: wr_ready=%0b swap_pending=%0b expected 1 0", wr_ready, swap_pending);
    end
    write_cells(1, 1'b1);
    checks++;
    if (wr_ready !== 1'b0 || swap_pending !== 1'b1) begin
      errors++; $display("FAIL full_after_last: wr_ready=%0b swap_pending=%0b expected 0 1", wr_ready, swap_pending);
    end
    do_swap();
    checks++;
    if (front_sel !== m_front[0] || frames_shown !== 8'(m_frames) || swap_pending !== 1'b0) begin
      errors++; $display("FAIL full_swap: front=%0b frames=%0d pend=%0b expected %0d %0d 0", front_sel, frames_shown, swap_pending, m_front, m_frames);
    end
    rd(3, 5, v);
    checks++;
    if (v !== 2'b01) begin errors++; $display("FAIL full_cell101: got %0d expected 1", v); end
    check_random_reads("full", 16);
  endtask

  task automatic test_drop();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    write_cells(N, 1'b0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    checks++;
    if (drop_err !== 1'b1 || swap_pending !== 1'b1 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL drop_pulse: drop=%0b pend=%0b ready=%0b expected 1 1 0", drop_err, swap_pending, wr_ready);
    end
    tick();
    checks++;
    if (drop_err !== 1'b0) begin errors++; $display("FAIL drop_once: got %0b expected 0", drop_err); end
    // Writes while waiting must not disturb the finished back bank.
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = CW'($urandom_range(0, 3)); tick();
    end
    wr_valid = 1'b0;
    frame_start = 1'b1; scan_frame_done = 1'b1; tick();
    frame_start = 1'b0; scan_frame_done = 1'b0;
    m_front = 1 - m_front; m_frames = (m_frames + 1) % 256; m_shown = 1; m_ptr = 0;
    checks++;
    if (drop_err !== 1'b1 || front_sel !== m_front[0] || frames_shown !== 8'(m_frames)
        || swap_pending !== 1'b0 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL drop_with_swap: drop=%0b front=%0b frames=%0d pend=%0b ready=%0b expected 1 %0d %0d 0 0",
                         drop_err, front_sel, frames_shown, swap_pending, wr_ready, m_front, m_frames);
    end
    check_random_reads("drop", 16);
  endtask

  task automatic test_same_cycle();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    write_cells(N - 1, 1'b0);
    wr_valid = 1'b1; wr_data = CW'($urandom_range(0, 3)); scan_frame_done = 1'b1;
    mb[1 - m_front][m_ptr] = wr_data; m_ptr++;
    tick();
    wr_valid = 1'b0; scan_frame_done = 1'b0;
    checks++;
    if (swap_pending !== 1'b1 || front_sel !== m_front[0] || frames_shown !== 8'(m_frames)) begin
      errors++; $display("FAIL same_cycle_noswap: pend=%0b front=%0b frames=%0d expected 1 %0d %0d", swap_pending, front_sel, frames_shown, m_front, m_frames);
    end
    tick();
    do_swap();
    checks++;
    if (swap_pending !== 1'b0 || front_sel !== m_front[0] || frames_shown !== 8'(m_frames)) begin
      errors++; $display("FAIL same_cycle_swap: pend=%0b front=%0b frames=%0d expected 0 %0d %0d", swap_pending, front_sel, frames_shown, m_front, m_frames);
    end
    check_random_reads("same_cycle", 12);
  endtask

  task automatic test_load_rules();
    logic [CW-1:0] v;
    wr_valid = 1'b1; frame_end = 1'b1; scan_frame_done = 1'b1; tick();
    wr_valid = 1'b0; frame_end = 1'b0; scan_frame_done = 1'b0;
    checks++;
    if (wr_ready !== 1'b0 || swap_pending !== 1'b0 || short_err !== 1'b0 || front_sel !== m_front[0]) begin
      errors++; $display("FAIL idle_ignore: ready=%0b pend=%0b short=%0b front=%0b", wr_ready, swap_pending, short_err, front_sel);
    end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    checks++;
    if (wr_ready !== 1'b0 || swap_pending !== 1'b0 || short_err !== 1'b0) begin
      errors++; $display("FAIL empty_frame_end: ready=%0b pend=%0b short=%0b expected 0 0 0", wr_ready, swap_pending, short_err);
    end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    write_cells(3, 1'b0);
    frame_start = 1'b1; wr_valid = 1'b1; wr_data = CW'($urandom_range(0, 3)); tick();
    frame_start = 1'b0; wr_valid = 1'b0;
    m_ptr = 0;
    write_cells(4, 1'b0);
    wr_valid = 1'b1; frame_end = 1'b1; wr_data = CW'($urandom_range(0, 3));
    mb[1 - m_front][m_ptr] = wr_data; m_ptr++;
    tick();
    wr_valid = 1'b0; frame_end = 1'b0;
    checks++;
    if (short_err !== 1'b1 || swap_pending !== 1'b1) begin
      errors++; $display("FAIL write_with_end: short=%0b pend=%0b expected 1 1", short_err, swap_pending);
    end
    do_swap();
    for (int c = 0; c < 8; c++) begin
      rd(0, c, v);
      checks++;
      if (v !== exp_color(0, c)) begin errors++; $display("FAIL abort_cells(%0d): got %0d expected %0d", c, v, exp_color(0, c)); end
    end
  endtask

  task automatic test_frames_wrap();
    for (int i = 0; i < 256; i++) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      write_cells(1, 1'b0);
      frame_end = 1'b1; tick(); frame_end = 1'b0;
      do_swap();
      checks++;
      if (frames_shown !== 8'(m_frames)) begin
        errors++; $display("FAIL frames_wrap[%0d]: got %0d expected %0d", i, frames_shown, m_frames);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [CW-1:0] v;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    write_cells(500, 1'b0);
    #3 reset = 1'b1;
    #1;
    m_front = 0; m_frames = 0; m_shown = 0; m_ptr = 0;
    checks++;
    if ({rd_color, wr_ready, swap_pending, front_sel, shown_valid, drop_err, short_err, frames_shown} !== '0) begin
      errors++; $display("FAIL reset_async: got %0h expected 0",
                         {rd_color, wr_ready, swap_pending, front_sel, shown_valid, drop_err, short_err, frames_shown});
    end
    tick(); reset = 1'b0; tick();
    rd(1, 2, v);
    checks++;
    if (v !== '0) begin errors++; $display("FAIL reset_blank: got %0d expected 0", v); end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    write_cells(N, 1'b0);
    do_swap();
    checks++;
    if (front_sel !== 1'b1 || frames_shown !== 8'd1 || shown_valid !== 1'b1) begin
      errors++; $display("FAIL reload_swap: front=%0b frames=%0d shown=%0b expected 1 1 1", front_sel, frames_shown, shown_valid);
    end
    check_random_reads("reload", 24);
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) mb[b][i] = '0;
    test_reset();
    test_short_frame();
    test_full_frame();
    test_drop();
    test_same_cycle();
    test_load_rules();
    test_frames_wrap();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
